// File: rtl/spi_port_master.sv
// ---------------------------------------------------------------------------
// spi_port_master
//   SPI master peripheral on the housekeeping CPU port bus. The CPU writes a
//   byte to TXDATA and the block shifts it out in SPI mode 0 (CPOL=0,
//   CPHA=0, MSB first). It drives CS, SCLK and MOSI with programmable timing
//   and captures MISO into RXDATA.
//
//   Register map (port_id relative to BASE_PORT):
//     +0  W: TXDATA (starts a transfer)   R: RXDATA
//     +1  W: CTRL [1:0] cs index, [2] cs_hold, [7] clear overrun
//         R: STATUS {6'd0, overrun, busy}
//     +2  R/W: DIV, half SCLK period H = DIV+1 clk cycles
//
// Ports
//   clk           system clock
//   reset         asynchronous, active-high reset
//   port_id       CPU port address
//   write_strobe  CPU write qualifier, one cycle
//   out_port      CPU write data
//   port_data     combinational read data for port_id (0 outside the block)
//   spi_sclk      serial clock, idles low
//   spi_mosi      serial data out
//   spi_miso      serial data in, already synchronous to clk
//   spi_cs_n      active-low chip selects
//   busy          transfer in progress
// ---------------------------------------------------------------------------
module spi_port_master #(
  parameter logic [7:0] BASE_PORT = 8'd40,
  parameter logic [7:0] DIV_RESET = 8'd3,
  parameter int         NCS       = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [7:0]     port_id,
  input  logic           write_strobe,
  input  logic [7:0]     out_port,
  output logic [7:0]     port_data,
  output logic           spi_sclk,
  output logic           spi_mosi,
  input  logic           spi_miso,
  output logic [NCS-1:0] spi_cs_n,
  output logic           busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_HIGH  = 3'd2;
  localparam logic [2:0] S_LOW   = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  localparam logic [NCS-1:0] CS_NONE = {NCS{1'b1}};

  // One-hot active-low select; an index at or beyond NCS selects nothing.
  function automatic logic [NCS-1:0] cs_decode(input logic [1:0] idx);
    logic [NCS-1:0] v;
    for (int i = 0; i < NCS; i++) begin
      v[i] = (idx == i[1:0]) ? 1'b0 : 1'b1;
    end
    return v;
  endfunction

  logic [2:0]     state_q,   state_d;
  logic [7:0]     cnt_q,     cnt_d;
  logic [2:0]     bit_q,     bit_d;
  logic [7:0]     shift_q,   shift_d;
  logic [7:0]     rxdata_q,  rxdata_d;
  logic [7:0]     div_q,     div_d;
  logic [1:0]     cs_idx_q,  cs_idx_d;
  logic           cs_hold_q, cs_hold_d;
  logic           overrun_q, overrun_d;
  logic           sclk_q,    sclk_d;
  logic           mosi_q,    mosi_d;
  logic [NCS-1:0] cs_n_q,    cs_n_d;
  logic           busy_q,    busy_d;

  logic wr_tx_s, wr_ctrl_s, wr_div_s, cnt_done_s;
  logic unused_ctrl_bits_s;

  assign wr_tx_s    = write_strobe && (port_id == BASE_PORT);
  assign wr_ctrl_s  = write_strobe && (port_id == (BASE_PORT + 8'd1));
  assign wr_div_s   = write_strobe && (port_id == (BASE_PORT + 8'd2));
  // Half-period counter runs 0..DIV; the explicit clear at terminal count
  // makes DIV=255 give 256 cycles without relying on overflow.
  assign cnt_done_s = (cnt_q == div_q);
  assign unused_ctrl_bits_s = ^out_port[6:3];

  // Next-state and datapath for the transfer sequencer and CPU registers.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    rxdata_d  = rxdata_q;
    div_d     = div_q;
    cs_idx_d  = cs_idx_q;
    cs_hold_d = cs_hold_q;
    overrun_d = overrun_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    cs_n_d    = cs_n_q;
    busy_d    = busy_q;

    // Overrun clear wins at any time; a TXDATA write while busy sets it.
    if (wr_ctrl_s && out_port[7]) begin
      overrun_d = 1'b0;
    end else if (wr_tx_s && busy_q) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = overrun_q;
    end

    case (state_q)
      S_IDLE: begin
        if (wr_tx_s) begin
          shift_d = out_port;
          mosi_d  = out_port[7];
          // Same index as a held CS decodes to the same value: no glitch.
          cs_n_d  = cs_decode(cs_idx_q);
          busy_d  = 1'b1;
          cnt_d   = 8'd0;
          bit_d   = 3'd0;
          sclk_d  = 1'b0;
          state_d = S_SETUP;
        end else if (wr_ctrl_s) begin
          cs_idx_d  = out_port[1:0];
          cs_hold_d = out_port[2];
          // Releasing hold or moving to another slave drops a held CS.
          if (!out_port[2] || (out_port[1:0] != cs_idx_q)) begin
            cs_n_d = CS_NONE;
          end else begin
            cs_n_d = cs_n_q;
          end
        end else if (wr_div_s) begin
          div_d = out_port;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_SETUP: begin
        if (cnt_done_s) begin
          cnt_d   = 8'd0;
          sclk_d  = 1'b1;
          shift_d = {shift_q[6:0], spi_miso};
          state_d = S_HIGH;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_HIGH: begin
        if (cnt_done_s) begin
          cnt_d   = 8'd0;
          sclk_d  = 1'b0;
          // After the last rise the shift register holds received data,
          // so MOSI keeps the final transmitted bit.
          if (bit_q == 3'd7) begin
            mosi_d = mosi_q;
          end else begin
            mosi_d = shift_q[7];
          end
          state_d = S_LOW;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_LOW: begin
        if (cnt_done_s) begin
          cnt_d = 8'd0;
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            rxdata_d = shift_q;
            if (cs_hold_q) begin
              busy_d  = 1'b0;
              state_d = S_IDLE;
            end else begin
              cs_n_d  = CS_NONE;
              state_d = S_GAP;
            end
          end else begin
            sclk_d  = 1'b1;
            shift_d = {shift_q[6:0], spi_miso};
            state_d = S_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_GAP: begin
        if (cnt_done_s) begin
          cnt_d   = 8'd0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
        sclk_d  = 1'b0;
        cs_n_d  = CS_NONE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and register update with asynchronous reset to safe outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      bit_q     <= 3'd0;
      shift_q   <= 8'd0;
      rxdata_q  <= 8'd0;
      div_q     <= DIV_RESET;
      cs_idx_q  <= 2'd0;
      cs_hold_q <= 1'b0;
      overrun_q <= 1'b0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= CS_NONE;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      rxdata_q  <= rxdata_d;
      div_q     <= div_d;
      cs_idx_q  <= cs_idx_d;
      cs_hold_q <= cs_hold_d;
      overrun_q <= overrun_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      cs_n_q    <= cs_n_d;
      busy_q    <= busy_d;
    end
  end

  // CPU read mux; ids outside the block read as zero.
  always_comb begin
    port_data = 8'h00;
    case (port_id)
      BASE_PORT:          port_data = rxdata_q;
      BASE_PORT + 8'd1:   port_data = {6'd0, overrun_q, busy_q};
      BASE_PORT + 8'd2:   port_data = div_q;
      default:            port_data = 8'h00;
    endcase
  end

  assign spi_sclk = sclk_q;
  assign spi_mosi = mosi_q;
  assign spi_cs_n = cs_n_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_spi_port_master.sv
// ---------------------------------------------------------------------------
// tb_spi_port_master
//   Directed bench for spi_port_master. Stimulus pushes the expected shape of
//   each transfer (busy length, CS-low length, selected CS, pulse count, half
//   period) into a queue; a monitor measures every transfer on the pins and
//   compares when busy falls. Register reads are checked directly.
// ---------------------------------------------------------------------------
module tb_spi_port_master;

  localparam logic [7:0] BASE = 8'd40;

  logic       clk;
  logic       reset;
  logic [7:0] port_id;
  logic       write_strobe;
  logic [7:0] out_port;
  logic [7:0] port_data;
  logic       spi_sclk;
  logic       spi_mosi;
  logic       spi_miso;
  logic [3:0] spi_cs_n;
  logic       busy;

  spi_port_master #(.BASE_PORT(8'd40), .DIV_RESET(8'd3), .NCS(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .port_id      (port_id),
    .write_strobe (write_strobe),
    .out_port     (out_port),
    .port_data    (port_data),
    .spi_sclk     (spi_sclk),
    .spi_mosi     (spi_mosi),
    .spi_miso     (spi_miso),
    .spi_cs_n     (spi_cs_n),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         busy_len;
    int         cs_low;
    logic [3:0] cs_vec;
    int         pulses;
    int         half;
  } xfer_exp_t;

  xfer_exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int aborts_issued = 0;

  // Slave model: loopback or shift out slave_byte, changing on SCLK fall.
  logic       loop_mode;
  logic [7:0] slave_byte;
  logic [7:0] slave_sr;

  always_comb spi_miso = loop_mode ? spi_mosi : slave_sr[7];

  initial begin
    logic prev_sclk;
    prev_sclk = 1'b0;
    slave_sr  = 8'h00;
    forever begin
      @(negedge clk);
      if (!busy) slave_sr = slave_byte;
      else if (prev_sclk && !spi_sclk) slave_sr = {slave_sr[6:0], 1'b0};
      prev_sclk = spi_sclk;
    end
  end

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // Transfer monitor / scoreboard.
  initial begin
    bit in_xfer, first;
    int busy_len, cs_low, pulses, hi_run, lo_run;
    int min_hi, max_hi, min_lo, max_lo, mosi_bad, aborts_seen;
    logic [3:0] cs_vec;
    logic prev_sclk, prev_mosi;
    xfer_exp_t e;
    in_xfer = 0; aborts_seen = 0;
    forever begin
      @(negedge clk);
      if (busy) begin
        if (!in_xfer) begin
          in_xfer = 1; first = 1;
          busy_len = 0; cs_low = 0; pulses = 0; hi_run = 0; lo_run = 0;
          min_hi = 1000; max_hi = 0; min_lo = 1000; max_lo = 0; mosi_bad = 0;
          cs_vec = spi_cs_n;
        end
        busy_len++;
        if (spi_cs_n != 4'hF) cs_low++;
        if (!first && (spi_mosi != prev_mosi) && !(prev_sclk && !spi_sclk)) mosi_bad++;
        if (spi_sclk) begin
          hi_run++;
          if (lo_run > 0) begin
            if (lo_run < min_lo) min_lo = lo_run;
            if (lo_run > max_lo) max_lo = lo_run;
            lo_run = 0;
          end
        end else begin
          lo_run++;
          if (hi_run > 0) begin
            pulses++;
            if (hi_run < min_hi) min_hi = hi_run;
            if (hi_run > max_hi) max_hi = hi_run;
            hi_run = 0;
          end
        end
        prev_sclk = spi_sclk; prev_mosi = spi_mosi; first = 0;
      end else if (in_xfer) begin
        in_xfer = 0;
        if (aborts_seen < aborts_issued) begin
          aborts_seen++;
        end else if (exp_q.size() == 0) begin
          check("unexpected_transfer", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("busy_len", busy_len, e.busy_len);
          check("cs_low_len", cs_low, e.cs_low);
          check("cs_vec", int'(cs_vec), int'(e.cs_vec));
          check("sclk_pulses", pulses, e.pulses);
          check("sclk_high_min", min_hi, e.half);
          check("sclk_high_max", max_hi, e.half);
          check("sclk_low_min", min_lo, e.half);
          check("sclk_low_max", max_lo, e.half);
          check("mosi_off_fall", mosi_bad, 0);
        end
      end
    end
  end

  task automatic wr(input logic [7:0] id, input logic [7:0] d);
    @(negedge clk);
    port_id = id; out_port = d; write_strobe = 1'b1;
    @(negedge clk);
    write_strobe = 1'b0;
  endtask

  task automatic rd(input string name, input logic [7:0] id, input logic [7:0] expv);
    port_id = id;
    #1;
    check(name, int'(port_data), int'(expv));
  endtask

  task automatic push(input int bl, input int cl, input logic [3:0] cv, input int h);
    xfer_exp_t e;
    e.busy_len = bl; e.cs_low = cl; e.cs_vec = cv; e.pulses = 8; e.half = h;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle(input string name, input int bound);
    bit done;
    done = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (!busy) begin done = 1; break; end
    end
    if (!done) check({name, "_timeout"}, 1, 0);
    @(negedge clk);  // let the monitor finish the transfer
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int rises;
    logic prev;
    reset = 1'b1; port_id = 8'h00; write_strobe = 1'b0; out_port = 8'h00;
    loop_mode = 1'b1; slave_byte = 8'h00;
    repeat (3) @(negedge clk);
    // reset values
    check("rst_sclk", int'(spi_sclk), 0);
    check("rst_mosi", int'(spi_mosi), 0);
    check("rst_cs_n", int'(spi_cs_n), 'hF);
    check("rst_busy", int'(busy), 0);
    reset = 1'b0;
    @(negedge clk);
    rd("rst_div", BASE + 8'd2, 8'd3);
    rd("rst_rx", BASE, 8'h00);
    rd("rst_status", BASE + 8'd1, 8'h00);

    // 1: DIV=0 loopback A5
    wr(BASE + 8'd2, 8'd0);
    wr(BASE + 8'd1, 8'h00);
    push(18, 17, 4'b1110, 1);
    wr(BASE, 8'hA5);
    wait_idle("t1", 100);
    rd("t1_rx", BASE, 8'hA5);
    rd("t1_status", BASE + 8'd1, 8'h00);

    // 2: DIV=3, slave returns 3C
    wr(BASE + 8'd2, 8'd3);
    rd("t2_div", BASE + 8'd2, 8'd3);
    loop_mode = 1'b0; slave_byte = 8'h3C;
    push(72, 68, 4'b1110, 4);
    wr(BASE, 8'hC5);
    wait_idle("t2", 400);
    rd("t2_rx", BASE, 8'h3C);
    loop_mode = 1'b1;

    // 3: TXDATA write mid-transfer -> overrun, transfer unaffected
    push(72, 68, 4'b1110, 4);
    wr(BASE, 8'h5A);
    repeat (10) @(negedge clk);
    wr(BASE, 8'hFF);
    rd("t3_status_busy", BASE + 8'd1, 8'h03);
    wait_idle("t3", 400);
    rd("t3_status_idle", BASE + 8'd1, 8'h02);
    rd("t3_rx", BASE, 8'h5A);
    wr(BASE + 8'd1, 8'h80);
    rd("t3_status_clr", BASE + 8'd1, 8'h00);

    // 4: held CS 2 across two bytes
    wr(BASE + 8'd1, 8'h06);
    push(68, 68, 4'b1011, 4);
    wr(BASE, 8'h12);
    wait_idle("t4a", 400);
    check("t4_cs_held_idle", int'(spi_cs_n), 'hB);
    rd("t4_rx1", BASE, 8'h12);
    push(68, 68, 4'b1011, 4);
    wr(BASE, 8'h34);
    check("t4_cs_held_start", int'(spi_cs_n), 'hB);
    wait_idle("t4b", 400);
    rd("t4_rx2", BASE, 8'h34);
    check("t4_cs_held_end", int'(spi_cs_n), 'hB);
    wr(BASE + 8'd1, 8'h02);
    check("t4_cs_release", int'(spi_cs_n), 'hF);

    // 5: reset during the 4th HIGH phase
    wr(BASE + 8'd1, 8'h00);
    wr(BASE + 8'd2, 8'd1);
    aborts_issued++;
    wr(BASE, 8'hC3);
    rises = 0; prev = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (spi_sclk && !prev) rises++;
      prev = spi_sclk;
      if (rises == 4) break;
      @(negedge clk);
    end
    check("t5_reached_high4", rises, 4);
    #1 reset = 1'b1;
    #1;
    check("t5_sclk", int'(spi_sclk), 0);
    check("t5_cs_n", int'(spi_cs_n), 'hF);
    check("t5_busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    rd("t5_div", BASE + 8'd2, 8'd3);
    rd("t5_rx", BASE, 8'h00);
    rd("t5_status", BASE + 8'd1, 8'h00);

    // 6: writes outside the block
    wr(BASE + 8'd3, 8'h55);
    wr(BASE - 8'd1, 8'h07);
    repeat (5) @(negedge clk);
    check("t6_busy", int'(busy), 0);
    rd("t6_pd_base3", BASE + 8'd3, 8'h00);
    rd("t6_pd_basem1", BASE - 8'd1, 8'h00);
    rd("t6_div", BASE + 8'd2, 8'd3);
    rd("t6_rx", BASE, 8'h00);
    rd("t6_status", BASE + 8'd1, 8'h00);

    repeat (3) @(negedge clk);
    check("pending_expected", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
